axi_mem_arbiter_2to1: RTL

- Shares one AXI4 memory port (SimDRAM-class DRAM model, or backing memory in real builds) between two AXI4 masters, e.g. a core and a DMA engine.
- Arbitrates AR and AW independently with round-robin priority.
- Tags outgoing IDs with the master index and routes R/B responses back by that tag.
- Sequences W beats in AW-grant order through a small grant FIFO, so write data is never interleaved.

---
 rtl/axi_mem_arbiter_2to1.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_arbiter_2to1.sv
// Two-master AXI4 arbiter onto one memory port: round-robin AR/AW grants, ID tagging
// with the master index, and W sequencing in AW-grant order through a small grant FIFO.
//
// state | meaning
// IDLE  | no grant held; picks a requester (AW also waits for W FIFO space)
// GRANT | grant registered; forwards the granted master until the memory handshake
module axi_mem_arbiter_2to1 #(
    parameter int ADDR_BITS   = 32,
    parameter int DATA_BITS   = 64,
    parameter int ID_BITS     = 4,
    parameter int WFIFO_DEPTH = 4,
    localparam int STRB_BITS  = DATA_BITS / 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 s0_ar_valid,
    input  logic [ADDR_BITS-1:0] s0_ar_addr,
    input  logic [ID_BITS-1:0]   s0_ar_id,
    input  logic [7:0]           s0_ar_len,
    input  logic [2:0]           s0_ar_size,
    output logic                 s0_ar_ready,
    input  logic                 s0_aw_valid,
    input  logic [ADDR_BITS-1:0] s0_aw_addr,
    input  logic [ID_BITS-1:0]   s0_aw_id,
    input  logic [7:0]           s0_aw_len,
    input  logic [2:0]           s0_aw_size,
    output logic                 s0_aw_ready,
    input  logic                 s0_w_valid,
    input  logic [DATA_BITS-1:0] s0_w_data,
    input  logic [STRB_BITS-1:0] s0_w_strb,
    input  logic                 s0_w_last,
    output logic                 s0_w_ready,
    output logic                 s0_r_valid,
    output logic [ID_BITS-1:0]   s0_r_id,
    output logic [1:0]           s0_r_resp,
    output logic [DATA_BITS-1:0] s0_r_data,
    output logic                 s0_r_last,
    input  logic                 s0_r_ready,
    output logic                 s0_b_valid,
    output logic [ID_BITS-1:0]   s0_b_id,
    output logic [1:0]           s0_b_resp,
    input  logic                 s0_b_ready,
    input  logic                 s1_ar_valid,
    input  logic [ADDR_BITS-1:0] s1_ar_addr,
    input  logic [ID_BITS-1:0]   s1_ar_id,
    input  logic [7:0]           s1_ar_len,
    input  logic [2:0]           s1_ar_size,
    output logic                 s1_ar_ready,
    input  logic                 s1_aw_valid,
    input  logic [ADDR_BITS-1:0] s1_aw_addr,
    input  logic [ID_BITS-1:0]   s1_aw_id,
    input  logic [7:0]           s1_aw_len,
    input  logic [2:0]           s1_aw_size,
    output logic                 s1_aw_ready,
    input  logic                 s1_w_valid,
    input  logic [DATA_BITS-1:0] s1_w_data,
    input  logic [STRB_BITS-1:0] s1_w_strb,
    input  logic                 s1_w_last,
    output logic                 s1_w_ready,
    output logic                 s1_r_valid,
    output logic [ID_BITS-1:0]   s1_r_id,
    output logic [1:0]           s1_r_resp,
    output logic [DATA_BITS-1:0] s1_r_data,
    output logic                 s1_r_last,
    input  logic                 s1_r_ready,
    output logic                 s1_b_valid,
    output logic [ID_BITS-1:0]   s1_b_id,
    output logic [1:0]           s1_b_resp,
    input  logic                 s1_b_ready,
    output logic                 m_ar_valid,
    output logic [ADDR_BITS-1:0] m_ar_addr,
    output logic [ID_BITS:0]     m_ar_id,
    output logic [7:0]           m_ar_len,
    output logic [2:0]           m_ar_size,
    input  logic                 m_ar_ready,
    output logic                 m_aw_valid,
    output logic [ADDR_BITS-1:0] m_aw_addr,
    output logic [ID_BITS:0]     m_aw_id,
    output logic [7:0]           m_aw_len,
    output logic [2:0]           m_aw_size,
    input  logic                 m_aw_ready,
    output logic                 m_w_valid,
    output logic [DATA_BITS-1:0] m_w_data,
    output logic [STRB_BITS-1:0] m_w_strb,
    output logic                 m_w_last,
    input  logic                 m_w_ready,
    input  logic                 m_r_valid,
    input  logic [ID_BITS:0]     m_r_id,
    input  logic [1:0]           m_r_resp,
    input  logic [DATA_BITS-1:0] m_r_data,
    input  logic                 m_r_last,
    output logic                 m_r_ready,
    input  logic                 m_b_valid,
    input  logic [ID_BITS:0]     m_b_id,
    input  logic [1:0]           m_b_resp,
    output logic                 m_b_ready
);
    localparam int PW = $clog2(WFIFO_DEPTH);

    typedef enum logic {IDLE, GRANT} arb_state_t;

    arb_state_t             ar_state, aw_state;
    logic                   ar_gnt, ar_ptr, aw_gnt, aw_ptr;
    logic [WFIFO_DEPTH-1:0] wq_mem;
    logic [PW:0]            wq_wr, wq_rd;
    logic                   wq_empty, wq_full, wq_head, wq_push, wq_pop;

    // Lone requester wins; on a tie the pointer names the favoured master.
    function automatic logic pick(input logic v0, input logic v1, input logic ptr);
        if (v0 && v1) return ptr;
        return v1 && !v0;
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ar_state <= IDLE;
            ar_gnt   <= 1'b0;
            ar_ptr   <= 1'b0;
        end else begin
            case (ar_state)
                IDLE:
                    if (s0_ar_valid || s1_ar_valid) begin
                        ar_gnt   <= pick(s0_ar_valid, s1_ar_valid, ar_ptr);
                        ar_state <= GRANT;
                    end
                GRANT:
                    if (m_ar_ready) begin
                        ar_ptr   <= ~ar_gnt;
                        ar_state <= IDLE;
                    end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            aw_state <= IDLE;
            aw_gnt   <= 1'b0;
            aw_ptr   <= 1'b0;
        end else begin
            case (aw_state)
                IDLE:
                    if ((s0_aw_valid || s1_aw_valid) && !wq_full) begin
                        aw_gnt   <= pick(s0_aw_valid, s1_aw_valid, aw_ptr);
                        aw_state <= GRANT;
                    end
                GRANT:
                    if (m_aw_ready) begin
                        aw_ptr   <= ~aw_gnt;
                        aw_state <= IDLE;
                    end
            endcase
        end
    end

    assign m_ar_valid  = (ar_state == GRANT);
    assign m_ar_addr   = ar_gnt ? s1_ar_addr : s0_ar_addr;
    assign m_ar_id     = {ar_gnt, (ar_gnt ? s1_ar_id : s0_ar_id)};
    assign m_ar_len    = ar_gnt ? s1_ar_len : s0_ar_len;
    assign m_ar_size   = ar_gnt ? s1_ar_size : s0_ar_size;
    assign s0_ar_ready = m_ar_valid && !ar_gnt && m_ar_ready;
    assign s1_ar_ready = m_ar_valid && ar_gnt && m_ar_ready;

    assign m_aw_valid  = (aw_state == GRANT);
    assign m_aw_addr   = aw_gnt ? s1_aw_addr : s0_aw_addr;
    assign m_aw_id     = {aw_gnt, (aw_gnt ? s1_aw_id : s0_aw_id)};
    assign m_aw_len    = aw_gnt ? s1_aw_len : s0_aw_len;
    assign m_aw_size   = aw_gnt ? s1_aw_size : s0_aw_size;
    assign s0_aw_ready = m_aw_valid && !aw_gnt && m_aw_ready;
    assign s1_aw_ready = m_aw_valid && aw_gnt && m_aw_ready;

    // Grant FIFO: one extra pointer bit separates full from empty.
    assign wq_empty = (wq_wr == wq_rd);
    assign wq_full  = (wq_wr[PW] != wq_rd[PW]) && (wq_wr[PW-1:0] == wq_rd[PW-1:0]);
    assign wq_head  = wq_mem[wq_rd[PW-1:0]];
    assign wq_push  = m_aw_valid && m_aw_ready;
    assign wq_pop   = m_w_valid && m_w_ready && m_w_last;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wq_mem <= '0;
            wq_wr  <= '0;
            wq_rd  <= '0;
        end else begin
            if (wq_push) begin
                wq_mem[wq_wr[PW-1:0]] <= aw_gnt;
                wq_wr                 <= wq_wr + 1'b1;
            end
            if (wq_pop)
                wq_rd <= wq_rd + 1'b1;
        end
    end

    assign m_w_valid  = !wq_empty && (wq_head ? s1_w_valid : s0_w_valid);
    assign m_w_data   = wq_head ? s1_w_data : s0_w_data;
    assign m_w_strb   = wq_head ? s1_w_strb : s0_w_strb;
    assign m_w_last   = wq_head ? s1_w_last : s0_w_last;
    assign s0_w_ready = !wq_empty && !wq_head && m_w_ready;
    assign s1_w_ready = !wq_empty && wq_head && m_w_ready;

    // Responses steer on the tag bit; gated so nothing handshakes while reset is held.
    assign s0_r_valid = !reset && m_r_valid && !m_r_id[ID_BITS];
    assign s1_r_valid = !reset && m_r_valid && m_r_id[ID_BITS];
    assign m_r_ready  = !reset && (m_r_id[ID_BITS] ? s1_r_ready : s0_r_ready);
    assign s0_r_id    = m_r_id[ID_BITS-1:0];
    assign s1_r_id    = m_r_id[ID_BITS-1:0];
    assign s0_r_resp  = m_r_resp;
    assign s1_r_resp  = m_r_resp;
    assign s0_r_data  = m_r_data;
    assign s1_r_data  = m_r_data;
    assign s0_r_last  = m_r_last;
    assign s1_r_last  = m_r_last;

    assign s0_b_valid = !reset && m_b_valid && !m_b_id[ID_BITS];
    assign s1_b_valid = !reset && m_b_valid && m_b_id[ID_BITS];
    assign m_b_ready  = !reset && (m_b_id[ID_BITS] ? s1_b_ready : s0_b_ready);
    assign s0_b_id    = m_b_id[ID_BITS-1:0];
    assign s1_b_id    = m_b_id[ID_BITS-1:0];
    assign s0_b_resp  = m_b_resp;
    assign s1_b_resp  = m_b_resp;
endmodule
